// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one single-port memory between NUM_REQ requesters,
// one transaction in flight, registered outputs, ready timeout abort.
module mem_rr_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int WIDTH      = 16,
   parameter int TIMEOUT    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_wr_rd,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]            req_done,
   output logic                          req_err,
   output logic [WIDTH-1:0]              resp_rdata,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic                          mem_wr_rd,
   output logic [WIDTH-1:0]              mem_wdata,
   output logic                          mem_valid,
   input  logic                          mem_ready,
   input  logic [WIDTH-1:0]              mem_rdata
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t                r_state, w_next;
   logic [GW-1:0]         r_ptr, r_grant, w_grant, w_idx;
   logic [CW-1:0]         r_cnt;
   logic                  w_any, w_timeout, w_end;
   logic [ADDR_WIDTH-1:0] w_addr_d;
   logic [WIDTH-1:0]      w_wdata_d, w_rdata_d;
   logic                  w_wr_rd_d, w_valid_d, w_err_d;
   logic [NUM_REQ-1:0]    w_done_d;
   // Descending scan so the requester closest to r_ptr is the last, winning, assignment
   always_comb begin
      w_grant = r_ptr;
      w_idx   = r_ptr;
      w_any   = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = GW'((int'(r_ptr) + k) % NUM_REQ);
         if (req_valid[w_idx]) begin
            w_grant = w_idx;
            w_any   = 1'b1;
         end
      end
   end
   assign w_timeout = (r_cnt == CW'(TIMEOUT - 1)) && !mem_ready;
   assign w_end     = mem_ready || w_timeout;
   always_comb begin
      w_next = (r_state == IDLE)  ? (w_any ? ISSUE : IDLE) :
               (r_state == ISSUE) ? (w_end ? RESP : ISSUE) : IDLE;
   end
   always_comb begin
      w_addr_d  = mem_addr;
      w_wr_rd_d = mem_wr_rd;
      w_wdata_d = mem_wdata;
      w_rdata_d = resp_rdata;
      w_valid_d = 1'b0;
      w_done_d  = '0;
      w_err_d   = 1'b0;
      if (r_state == IDLE && w_any) begin
         w_addr_d  = req_addr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
         w_wr_rd_d = req_wr_rd[w_grant];
         w_wdata_d = req_wdata[w_grant*WIDTH +: WIDTH];
         w_valid_d = 1'b1;
      end else if (r_state == ISSUE) begin
         w_valid_d          = !w_end;
         w_done_d[r_grant]  = w_end;
         w_err_d            = w_timeout;
         w_rdata_d          = (mem_ready && !mem_wr_rd) ? mem_rdata : resp_rdata;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_cnt      <= '0;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wr_rd  <= 1'b0;
         mem_wdata  <= '0;
         req_done   <= '0;
         req_err    <= 1'b0;
         resp_rdata <= '0;
      end else begin
         r_state    <= w_next;
         mem_valid  <= w_valid_d;
         mem_addr   <= w_addr_d;
         mem_wr_rd  <= w_wr_rd_d;
         mem_wdata  <= w_wdata_d;
         req_done   <= w_done_d;
         req_err    <= w_err_d;
         resp_rdata <= w_rdata_d;
         if (r_state == IDLE) begin
            r_grant <= w_grant;
            r_cnt   <= '0;
         end else if (r_state == ISSUE) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == RESP)
            r_ptr <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
      end
   end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one single-port `memory` instance (valid/ready handshake, `wr_rd`=1 write, 0 read) between NUM_REQ front-door requesters.
- Round-robin arbitration; one transaction outstanding at a time.
- Latches the granted request, drives it into the memory, returns read data and a one-cycle done pulse, and aborts with an error after a ready timeout.
- Sits between requester blocks (DMA, CPU port, bench drivers) and the memory.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DEPTH, 64, memory depth in words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- WIDTH, 16, data width.
- TIMEOUT, 32, cycles allowed in ISSUE before abort (>=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request; bit i belongs to requester i.
- req_wr_rd  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  1  high with req_done when the transaction timed out.
- resp_rdata  out  WIDTH  read data; valid while req_done is high after a read.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wr_rd  out  1  to memory wr_rd.
- mem_wdata  out  WIDTH  to memory wdata.
- mem_valid  out  1  to memory valid.
- mem_ready  in  1  from memory ready.
- mem_rdata  in  WIDTH  from memory rdata.

Behaviour:
- Reset: all outputs are registered.
  - While rst=1 at a posedge: state=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs are 0: mem_valid, mem_addr, mem_wr_rd, mem_wdata, req_done, req_err, resp_rdata.
  - Reset mid-transaction drops mem_valid at that edge, with no done pulse and no error.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Latch that requester's addr, wr_rd and wdata into mem_addr, mem_wr_rd and mem_wdata.
  - Set mem_valid=1, clear the counter, go to ISSUE.
  - Otherwise stay; outputs hold and mem_valid=0.
- ISSUE:
  - mem_valid=1; mem_addr, mem_wr_rd and mem_wdata are held stable.
  - On an edge with mem_ready=1: mem_valid<=0; resp_rdata<=mem_rdata (reads only; unchanged on writes); req_done[grant]<=1; req_err<=0; go to RESP.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and mem_ready=0: mem_valid<=0; req_done[grant]<=1; req_err<=1; resp_rdata unchanged; go to RESP.
  - mem_ready sampled on the same edge as the timeout wins (normal completion).
- RESP:
  - req_done and req_err are high for exactly this one cycle, then cleared.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - Go to IDLE.
  - mem_valid=0 during RESP guarantees at least one idle cycle between memory transactions.
- Latency:
  - A request seen in IDLE at edge T gives mem_valid high after T.
  - With ready answered at edge T+k (k>=1), req_done is high from T+k to T+k+1.
  - Minimum request-to-done latency is 2 edges; back-to-back grants are 3 cycles apart.
- Requester rules:
  - Requester holds req_valid and its fields until it sees its req_done.
  - Changes to req_* after the grant edge are ignored (the request is latched).
  - A requester deasserting req_valid before its grant is simply not served.
  - If req_valid is still high in the cycle after req_done, it is a new request.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,... and none waits more than NUM_REQ-1 transactions.
- Addresses pass through unmodified; no range check (ADDR_WIDTH covers DEPTH).

Test Plan:
- Single write then read: req0 writes addr 5 = 16'hA5A5, then reads addr 5 -> mem_wr_rd 1 then 0, each req_done[0] a single cycle, resp_rdata=16'hA5A5, req_err=0.
- Simultaneous requests after reset: req0 writes addr 0 = 16'h1111, req1 writes addr 1 = 16'h2222, both held.
  - req0 is granted first, then req1.
  - Backdoor check of DUT memory shows mem[0]=16'h1111 and mem[1]=16'h2222.
- Continuous contention: both requesters issue 8 reads each, always valid -> grant order 0,1,0,1,...; each requester gets exactly 8 req_done pulses; mem_valid is low for at least 1 cycle between transactions.
- Timeout: stub memory never asserts ready, TIMEOUT=32 -> mem_valid is high for exactly 32 cycles, then req_done[grant]=1 with req_err=1; the next request is served normally.
- Reset mid-ISSUE: assert rst for 1 cycle while mem_valid=1 -> mem_valid=0 after that edge, no req_done, rr_ptr=0; a subsequent request from requester 1 alone is granted.
- Frontdoor/backdoor consistency: $readmemh image into memory, then read all 64 locations through req1 -> every resp_rdata matches the image file.
